input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 181 ++++++++++++++++++
 tb/tb_input_conditioner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Purpose : synchronises the slide switches and the Enter key, debounces the key, and
//           on each accepted press captures the switches into a one-deep data register.
// Latency : enter_pulse is asserted DEBOUNCE_CYCLES+3 edges after key_n is first sampled low.
//           sw_sync lags sw_raw by 2 edges.
// Backpressure: none. The CPU consumes data on an ack rising edge. A capture over
//           unconsumed data sets the sticky overrun flag.
//
// Ports:
//   CLK         system clock; all state changes on its rising edge
//   reset       asynchronous, active-low clear of all state
//   key_n       raw bouncing Enter pushbutton, active-low
//   sw_raw      raw slide switches
//   ack         CPU Input-instruction strobe; only its rising edge is used
//   sw_sync     synchronised switches
//   enter_pulse one-cycle strobe per accepted press
//   pressed     debounced key level (1 = held)
//   data_out    {22'b0, sw_sync} captured at press acceptance
//   data_valid  captured data not yet consumed
//   overrun     sticky: a capture overwrote unconsumed data
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        key_n,
    input  logic [9:0]  sw_raw,
    input  logic        ack,
    output logic [9:0]  sw_sync,
    output logic        enter_pulse,
    output logic        pressed,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        overrun
);

    // The counter only has to hold DEBOUNCE_CYCLES-1.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            key_meta_q, key_sync_q;
    logic [9:0]      sw_meta_q, sw_sync_q;
    logic            ack_d_q;
    logic            pulse_q;
    logic [9:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic            accept;
    logic            ack_rise;

    // Synchronisers. The key flops reset to 1, which is the released level,
    // so a key held through reset still needs a full debounce afterwards.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            ack_d_q    <= 1'b0;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= sw_raw;
            sw_sync_q  <= sw_meta_q;
            ack_d_q    <= ack;
        end
    end

    assign ack_rise = ack & ~ack_d_q;

    // Debounce FSM: the state register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. Any opposing sample restarts the count, so the counter
    // never wraps. It is cleared whenever the FSM changes state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_sync_q) begin
                    state_d = ARMING;
                    cnt_d   = '0;
                end
            end
            ARMING: begin
                if (key_sync_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (key_sync_q) begin
                    state_d = RELEASING;
                    cnt_d   = '0;
                end
            end
            RELEASING: begin
                if (!key_sync_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture register. When a capture and an ack edge coincide, the capture
    // wins: the new data stays valid. The ack still counts as consuming the
    // old data, so overrun is cleared.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (accept) begin
            data_d  = sw_sync_q;
            valid_d = 1'b1;
            if (ack_rise) begin
                overrun_d = 1'b0;
            end else if (valid_q) begin
                overrun_d = 1'b1;
            end
        end else if (ack_rise) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pulse_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pulse_q   <= accept;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sw_sync     = sw_sync_q;
    assign enter_pulse = pulse_q;
    assign pressed     = (state_q == PRESSED) || (state_q == RELEASING);
    assign data_out    = {22'b0, data_q};
    assign data_valid  = valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Purpose : checks input_conditioner (DEBOUNCE_CYCLES = 4) against a run-length
//           debounce model, using directed scenarios and then random key/switch/ack traffic.
// Ports   : drives CLK, reset, key_n, sw_raw and ack, and observes all outputs.
module tb_input_conditioner;

    localparam int D = 4;

    logic        CLK;
    logic        reset;
    logic        key_n;
    logic [9:0]  sw_raw;
    logic        ack;
    logic [9:0]  sw_sync;
    logic        enter_pulse;
    logic        pressed;
    logic [31:0] data_out;
    logic        data_valid;
    logic        overrun;

    int n_checks = 0;
    int n_pass   = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .key_n      (key_n),
        .sw_raw     (sw_raw),
        .ack        (ack),
        .sw_sync    (sw_sync),
        .enter_pulse(enter_pulse),
        .pressed    (pressed),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model. The debounced level flips after D+1 consecutive
    // synchronised samples that oppose it. A flip to "held" is an accepted press.
    // Raw inputs reach the logic two edges late, so they are modelled as a 2-deep history.
    logic       key_q[$];
    logic [9:0] sw_q[$];
    logic       m_level;
    int         m_run;
    logic       m_pulse;
    logic [9:0] m_data;
    logic       m_valid;
    logic       m_overrun;
    logic       m_ack_prev;
    logic [9:0] m_sw_sync;

    task automatic model_reset();
        key_q.delete(); key_q.push_back(1'b1); key_q.push_back(1'b1);
        sw_q.delete();  sw_q.push_back(10'h0); sw_q.push_back(10'h0);
        m_level = 0; m_run = 0; m_pulse = 0; m_data = 0;
        m_valid = 0; m_overrun = 0; m_ack_prev = 0; m_sw_sync = 0;
    endtask

    task automatic model_step();
        logic       ks;
        logic [9:0] sws;
        logic       acc;
        logic       rise;
        ks  = key_q.pop_front(); key_q.push_back(key_n);
        sws = sw_q.pop_front();  sw_q.push_back(sw_raw);
        m_sw_sync = sw_q[0];
        acc = 0;
        // While released, key=0 opposes the level. While held, key=1 opposes it.
        if (ks == m_level) begin
            m_run++;
            if (m_run == D + 1) begin
                m_level = ~m_level;
                m_run   = 0;
                acc     = m_level;
            end
        end else begin
            m_run = 0;
        end
        rise = ack && !m_ack_prev;
        m_ack_prev = ack;
        if (acc) begin
            if (rise)         m_overrun = 0;
            else if (m_valid) m_overrun = 1;
            m_data  = sws;
            m_valid = 1;
        end else if (rise) begin
            m_valid   = 0;
            m_overrun = 0;
        end
        m_pulse = acc;
    endtask

    // One clock: the model consumes the inputs seen at the edge. Control then
    // returns 1 ns after the edge, where outputs are sampled and inputs may change.
    task automatic tick();
        @(posedge CLK);
        if (!reset) model_reset();
        else        model_step();
        #1;
    endtask

    task automatic press(input logic [9:0] v);
        sw_raw = v;
        key_n  = 0;
        repeat (12) tick();
        key_n  = 1;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        reset = 0; key_n = 1; sw_raw = 10'h3FF; ack = 0;
        model_reset();
        #2;
        n_checks++; if (sw_sync !== 10'h0) $display("FAIL reset_sw_sync got %h want 0", sw_sync); else n_pass++;
        n_checks++; if ({enter_pulse, pressed, data_valid, overrun} !== 4'b0)
            $display("FAIL reset_flags got %b want 0000", {enter_pulse, pressed, data_valid, overrun}); else n_pass++;
        n_checks++; if (data_out !== 32'h0) $display("FAIL reset_data got %h want 0", data_out); else n_pass++;
        repeat (3) tick();
        n_checks++; if (sw_sync !== 10'h0) $display("FAIL reset_hold_sw got %h want 0", sw_sync); else n_pass++;
        reset = 1; sw_raw = 10'h0;
        repeat (4) tick();
    endtask

    task automatic test_press();
        int  n;
        int  extra;
        bit  got;
        key_n = 1; sw_raw = 10'h155; ack = 0;
        repeat (6) tick();
        key_n = 0; n = 0; got = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            tick();
            if (enter_pulse === 1'b1) begin got = 1; n = i; end
        end
        n_checks++; if (n != D + 3) $display("FAIL press_latency got %0d want %0d", n, D + 3); else n_pass++;
        n_checks++; if (data_out !== 32'h155) $display("FAIL press_data got %h want 155", data_out); else n_pass++;
        n_checks++; if (data_valid !== 1'b1 || pressed !== 1'b1)
            $display("FAIL press_flags got v=%b p=%b want 1 1", data_valid, pressed); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL press_overrun got %b want 0", overrun); else n_pass++;
        extra = 0;
        repeat (30) begin tick(); if (enter_pulse !== 1'b0) extra++; end
        n_checks++; if (extra != 0) $display("FAIL press_single_pulse got %0d extra want 0", extra); else n_pass++;
        n_checks++; if (pressed !== 1'b1) $display("FAIL press_held got %b want 1", pressed); else n_pass++;
    endtask

    task automatic test_ack_hold();
        int bad;
        ack = 1;
        tick();
        n_checks++; if (data_valid !== 1'b0) $display("FAIL ack_clear got %b want 0", data_valid); else n_pass++;
        bad = 0;
        repeat (9) begin
            tick();
            if (data_valid !== 1'b0 || data_out !== 32'h155 || overrun !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL ack_hold got %0d bad cycles want 0", bad); else n_pass++;
        ack = 0; key_n = 1;
        repeat (12) tick();
        n_checks++; if (pressed !== 1'b0) $display("FAIL release got %b want 0", pressed); else n_pass++;
    endtask

    task automatic test_bounce();
        int pulses;
        int held;
        pulses = 0; held = 0;
        for (int i = 0; i < 40; i++) begin
            key_n = ((i % 4) == 3);
            tick();
            if (enter_pulse !== 1'b0) pulses++;
            if (pressed !== 1'b0) held++;
        end
        key_n = 1;
        repeat (8) begin tick(); if (enter_pulse !== 1'b0) pulses++; if (pressed !== 1'b0) held++; end
        n_checks++; if (pulses != 0) $display("FAIL bounce_pulse got %0d want 0", pulses); else n_pass++;
        n_checks++; if (held != 0) $display("FAIL bounce_pressed got %0d want 0", held); else n_pass++;
    endtask

    task automatic test_overrun();
        press(10'h001);
        press(10'h2AA);
        n_checks++; if (data_out !== 32'h2AA) $display("FAIL overrun_data got %h want 2aa", data_out); else n_pass++;
        n_checks++; if (data_valid !== 1'b1 || overrun !== 1'b1)
            $display("FAIL overrun_flags got v=%b o=%b want 1 1", data_valid, overrun); else n_pass++;
        ack = 1;
        tick();
        n_checks++; if (data_valid !== 1'b0 || overrun !== 1'b0)
            $display("FAIL overrun_ack got v=%b o=%b want 0 0", data_valid, overrun); else n_pass++;
        ack = 0;
        tick();
    endtask

    task automatic test_ack_accept();
        press(10'h111);
        sw_raw = 10'h3C3; key_n = 0;
        repeat (D + 2) tick();
        ack = 1;
        tick();
        n_checks++; if (enter_pulse !== 1'b1) $display("FAIL coincide_pulse got %b want 1", enter_pulse); else n_pass++;
        n_checks++; if (data_out !== 32'h3C3) $display("FAIL coincide_data got %h want 3c3", data_out); else n_pass++;
        n_checks++; if (data_valid !== 1'b1 || overrun !== 1'b0)
            $display("FAIL coincide_flags got v=%b o=%b want 1 0", data_valid, overrun); else n_pass++;
        ack = 0; key_n = 1;
        repeat (12) tick();
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  got;
        sw_raw = 10'h0F0; key_n = 0;
        repeat (5) tick();
        n_checks++; if (pressed !== 1'b0 || enter_pulse !== 1'b0)
            $display("FAIL arming_state got p=%b e=%b want 0 0", pressed, enter_pulse); else n_pass++;
        reset = 0;
        model_reset();
        #2;
        n_checks++; if ({sw_sync, enter_pulse, pressed, data_valid, overrun} !== 14'b0)
            $display("FAIL midreset_flags got %h want 0", {sw_sync, enter_pulse, pressed, data_valid, overrun}); else n_pass++;
        n_checks++; if (data_out !== 32'h0) $display("FAIL midreset_data got %h want 0", data_out); else n_pass++;
        tick(); tick();
        reset = 1;
        n = 0; got = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            tick();
            if (enter_pulse === 1'b1) begin got = 1; n = i; end
        end
        n_checks++; if (n != D + 3) $display("FAIL postreset_latency got %0d want %0d", n, D + 3); else n_pass++;
        n_checks++; if (data_out !== 32'h0F0) $display("FAIL postreset_data got %h want 0f0", data_out); else n_pass++;
        key_n = 1;
        repeat (12) tick();
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                key_n = 1'($urandom_range(0, 1));
                hold  = $urandom_range(1, 9);
            end
            hold--;
            if ($urandom_range(0, 7) == 0) ack = ~ack;
            sw_raw = 10'($urandom);
            tick();
            n_checks++; if (enter_pulse !== m_pulse) $display("FAIL rnd_pulse cyc %0d got %b want %b", i, enter_pulse, m_pulse); else n_pass++;
            n_checks++; if (pressed !== m_level) $display("FAIL rnd_pressed cyc %0d got %b want %b", i, pressed, m_level); else n_pass++;
            n_checks++; if (data_out !== {22'b0, m_data}) $display("FAIL rnd_data cyc %0d got %h want %h", i, data_out, m_data); else n_pass++;
            n_checks++; if (data_valid !== m_valid) $display("FAIL rnd_valid cyc %0d got %b want %b", i, data_valid, m_valid); else n_pass++;
            n_checks++; if (overrun !== m_overrun) $display("FAIL rnd_overrun cyc %0d got %b want %b", i, overrun, m_overrun); else n_pass++;
            n_checks++; if (sw_sync !== m_sw_sync) $display("FAIL rnd_sw_sync cyc %0d got %h want %h", i, sw_sync, m_sw_sync); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_ack_hold();
        test_bounce();
        test_overrun();
        test_ack_accept();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
